count_seq_checker: RTL and testbench

- Receive-side checker for the WIDTH-bit free-running up-counter output; consumes the `value` bus that the counter drives.
- Locks onto the incrementing sequence, flags every broken step, and counts errors and wrap-arounds.
- Sits next to `counter` in benches and in-system self-test; shares its clock and reset.

---
 rtl/count_seq_checker.sv | 140 ++++++++++++++
 tb/tb_count_seq_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Receive-side checker for a free-running up-counter: locks onto the increment
// sequence, flags broken steps and counts errors and wraps. Optional macro: COUNT_CHECK_RESTART_EN.
module count_seq_checker #(
    parameter int WIDTH     = 10,
    parameter int ERR_WIDTH = 8,
    parameter int SYNC_LEN  = 4,
    parameter int MAX_MISS  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     value,
    input  logic                 sample_en,
    output logic                 locked,
    output logic                 error,
    output logic [WIDTH-1:0]     expected,
    output logic [ERR_WIDTH-1:0] err_count,
`ifdef COUNT_CHECK_RESTART_EN
    output logic                 restart,
`endif
    output logic [ERR_WIDTH-1:0] wrap_count
);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [3:0]       SYNC_TGT = 4'(SYNC_LEN);
    localparam logic [3:0]       MISS_TGT = 4'(MAX_MISS);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic [3:0]           good_run_q, good_run_d;
    logic [3:0]           miss_run_q, miss_run_d;
    logic [ERR_WIDTH-1:0] err_count_q, err_count_d;
    logic [ERR_WIDTH-1:0] wrap_count_q, wrap_count_d;
    logic                 error_q, error_d;
    logic                 restart_q, restart_d;
    logic                 match;
    logic                 restart_hit;

    // Comparison is done in WIDTH bits so all-ones followed by zero counts as a match.
    assign match = (value == prev_q + ONE);

`ifdef COUNT_CHECK_RESTART_EN
    assign restart_hit = (value == '0) && (prev_q != '1);
`else
    assign restart_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        expected_d   = expected_q;
        good_run_d   = good_run_q;
        miss_run_d   = miss_run_q;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        error_d      = 1'b0;
        restart_d    = 1'b0;
        if (sample_en) begin
            prev_d     = value;
            expected_d = value + ONE;
            case (state_q)
                HUNT: begin
                    state_d    = SYNC;
                    good_run_d = '0;
                end
                SYNC: begin
                    if (match) begin
                        good_run_d = good_run_q + 4'd1;
                        if (good_run_q + 4'd1 == SYNC_TGT) begin
                            state_d    = LOCKED;
                            miss_run_d = '0;
                        end
                    end else begin
                        good_run_d = '0;
                    end
                end
                LOCKED: begin
                    if (restart_hit) begin
                        restart_d  = 1'b1;
                        miss_run_d = '0;
                    end else if (match) begin
                        miss_run_d = '0;
                        if (prev_q == '1 && wrap_count_q != '1)
                            wrap_count_d = wrap_count_q + 1'b1;
                    end else begin
                        error_d    = 1'b1;
                        miss_run_d = miss_run_q + 4'd1;
                        if (err_count_q != '1)
                            err_count_d = err_count_q + 1'b1;
                        // Too many back-to-back misses means the stream is lost; resync.
                        if (miss_run_q + 4'd1 == MISS_TGT) begin
                            state_d    = SYNC;
                            good_run_d = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            prev_q       <= '0;
            expected_q   <= '0;
            good_run_q   <= '0;
            miss_run_q   <= '0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
            error_q      <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            expected_q   <= expected_d;
            good_run_q   <= good_run_d;
            miss_run_q   <= miss_run_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
            error_q      <= error_d;
            restart_q    <= restart_d;
        end
    end

    assign locked     = (state_q == LOCKED);
    assign error      = error_q;
    assign expected   = expected_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;
`ifdef COUNT_CHECK_RESTART_EN
    assign restart    = restart_q;
`else
    logic unused_restart;
    assign unused_restart = restart_q;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: two instances (default sizing and WIDTH=4/ERR_WIDTH=2)
// checked every cycle against a rule-level model, plus literal expectations.
module tb_count_seq_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [31:0] stimVal;

    logic       lockedA, errorA;
    logic [9:0] expectedA;
    logic [7:0] errCountA, wrapCountA;
    logic       lockedB, errorB;
    logic [3:0] expectedB;
    logic [1:0] errCountB, wrapCountB;
    logic       restartA, restartB;

    int vectors    = 0;
    int miscompares = 0;
    bit modelValid = 0;

    always #5 clk = ~clk;

`ifdef COUNT_CHECK_RESTART_EN
    localparam bit RESTART_EN = 1'b1;
`else
    localparam bit RESTART_EN = 1'b0;
    assign restartA = 1'b0;
    assign restartB = 1'b0;
`endif

    count_seq_checker #(.WIDTH(10), .ERR_WIDTH(8)) dutA (
        .clk(clk), .reset(reset), .value(stimVal[9:0]), .sample_en(sample_en),
        .locked(lockedA), .error(errorA), .expected(expectedA),
        .err_count(errCountA),
`ifdef COUNT_CHECK_RESTART_EN
        .restart(restartA),
`endif
        .wrap_count(wrapCountA));

    count_seq_checker #(.WIDTH(4), .ERR_WIDTH(2)) dutB (
        .clk(clk), .reset(reset), .value(stimVal[3:0]), .sample_en(sample_en),
        .locked(lockedB), .error(errorB), .expected(expectedB),
        .err_count(errCountB),
`ifdef COUNT_CHECK_RESTART_EN
        .restart(restartB),
`endif
        .wrap_count(wrapCountB));

    // Rule-level model: phase 0=hunting, 1=syncing, 2=locked.
    typedef struct {
        int phase; int prev; int good; int miss;
        int errs; int wraps; int errPulse; int rstPulse; int expv;
    } model_t;

    model_t mA, mB;

    function automatic model_t step(model_t m, bit rst, bit en, int val, int width, int ewidth);
        int mask = (1 << width) - 1;
        int emax = (1 << ewidth) - 1;
        int v    = val & mask;
        model_t r = m;
        if (rst) begin
            r = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
            return r;
        end
        r.errPulse = 0;
        r.rstPulse = 0;
        if (!en) return r;
        if (m.phase == 0) begin
            r.phase = 1;
            r.good  = 0;
        end else if (m.phase == 1) begin
            if (v == ((m.prev + 1) & mask)) begin
                r.good = m.good + 1;
                if (r.good == 4) begin r.phase = 2; r.miss = 0; end
            end else r.good = 0;
        end else begin
            if (RESTART_EN && v == 0 && m.prev != mask) begin
                r.rstPulse = 1;
                r.miss     = 0;
            end else if (v == ((m.prev + 1) & mask)) begin
                r.miss = 0;
                if (m.prev == mask) r.wraps = (m.wraps < emax) ? m.wraps + 1 : emax;
            end else begin
                r.errPulse = 1;
                r.errs     = (m.errs < emax) ? m.errs + 1 : emax;
                r.miss     = m.miss + 1;
                if (r.miss == 3) begin r.phase = 1; r.good = 0; end
            end
        end
        r.prev = v;
        r.expv = (v + 1) & mask;
        return r;
    endfunction

    task automatic checkOutput(string name, int actual, int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, actual, required, $time);
        end
    endtask

    always @(posedge clk) begin
        mA = step(mA, reset, sample_en, int'(stimVal), 10, 8);
        mB = step(mB, reset, sample_en, int'(stimVal), 4, 2);
        if (reset) modelValid = 1;
    end

    // Every cycle after the first reset, both instances must agree with the model.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("A.locked",   int'(lockedA),    int'(mA.phase == 2));
            checkOutput("A.error",    int'(errorA),     mA.errPulse);
            checkOutput("A.expected", int'(expectedA),  mA.expv);
            checkOutput("A.errCount", int'(errCountA),  mA.errs);
            checkOutput("A.wrapCount",int'(wrapCountA), mA.wraps);
            checkOutput("A.restart",  int'(restartA),   mA.rstPulse);
            checkOutput("B.locked",   int'(lockedB),    int'(mB.phase == 2));
            checkOutput("B.error",    int'(errorB),     mB.errPulse);
            checkOutput("B.expected", int'(expectedB),  mB.expv);
            checkOutput("B.errCount", int'(errCountB),  mB.errs);
            checkOutput("B.wrapCount",int'(wrapCountB), mB.wraps);
            checkOutput("B.restart",  int'(restartB),   mB.rstPulse);
        end
    end

    task automatic applyStimulus(bit rst, bit en, int val);
        @(negedge clk);
        reset     = rst;
        sample_en = en;
        stimVal   = val;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(int vals[$]);
        foreach (vals[i]) applyStimulus(0, 1, vals[i]);
    endtask

    initial begin
        reset = 1'b1; sample_en = 1'b0; stimVal = 0;
        mA = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        mB = mA;

        // Reset two cycles, then count 0..4 to lock
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        settle();
        checkOutput("pin.reset.A.locked", int'(lockedA), 0);
        checkOutput("pin.reset.A.expected", int'(expectedA), 0);
        feed('{0, 1, 2, 3, 4});
        settle();
        checkOutput("pin.lock.A.locked", int'(lockedA), 1);
        checkOutput("pin.lock.A.expected", int'(expectedA), 5);

        // Single jump: one error, lock held
        feed('{7, 8, 9});
        settle();
        checkOutput("pin.jump.A.errCount", int'(errCountA), 1);
        checkOutput("pin.jump.A.locked", int'(lockedA), 1);
        checkOutput("pin.jump.A.expected", int'(expectedA), 10);

        // Three consecutive misses drop lock; relock on a clean run
        applyStimulus(1, 0, 0);
        feed('{0, 1, 2, 3, 4, 9, 2, 11});
        settle();
        checkOutput("pin.drop.A.locked", int'(lockedA), 0);
        checkOutput("pin.drop.A.errCount", int'(errCountA), 3);
        feed('{12, 13, 14, 15, 16});
        settle();
        checkOutput("pin.relock.A.locked", int'(lockedA), 1);
        checkOutput("pin.relock.A.errCount", int'(errCountA), 3);

        // Gaps in sample_en hold everything
        applyStimulus(0, 0, 99);
        applyStimulus(0, 0, 3);
        settle();
        checkOutput("pin.hold.A.expected", int'(expectedA), 17);

        // Counter restart to zero while locked
        applyStimulus(1, 0, 0);
        feed('{16, 17, 18, 19, 20, 21, 0, 1});
        settle();
        checkOutput("pin.restart.A.locked", int'(lockedA), 1);
        checkOutput("pin.restart.A.errCount", int'(errCountA), RESTART_EN ? 0 : 1);
        checkOutput("pin.restart.A.expected", int'(expectedA), 2);

        // 4-bit instance: wrap through all-ones
        applyStimulus(1, 0, 0);
        feed('{8, 9, 10, 11, 12, 13, 14, 15, 0, 1});
        settle();
        checkOutput("pin.wrap.B.wrapCount", int'(wrapCountB), 1);
        checkOutput("pin.wrap.B.expected", int'(expectedB), 2);
        checkOutput("pin.wrap.B.errCount", int'(errCountB), 0);

        // Five isolated mismatches saturate the 2-bit error counter
        feed('{5, 6, 9, 10, 13, 14, 1, 2, 5, 6});
        settle();
        checkOutput("pin.sat.B.errCount", int'(errCountB), 3);
        checkOutput("pin.sat.B.locked", int'(lockedB), 1);

        // Mid-stream reset wins over sample_en
        applyStimulus(1, 1, 7);
        settle();
        checkOutput("pin.midreset.B.errCount", int'(errCountB), 0);
        checkOutput("pin.midreset.B.locked", int'(lockedB), 0);
        checkOutput("pin.midreset.B.expected", int'(expectedB), 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
